// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM front end: registers and decodes host commands, runs the power-up
// init sequence, then schedules periodic refreshes with a postponement queue.
module sdram_init_refresh_ctrl #(
  parameter int ASIZE        = 23,
  parameter int INIT_CYCLES  = 20000,
  parameter int INIT_REFRESH = 8,
  parameter int REF_GAP      = 20,
  parameter int REF_PER      = 768,
  parameter int MAX_PENDING  = 8
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [2:0]                         CMD,
  input  logic [ASIZE-1:0]                   ADDR,
  input  logic                               CM_ACK,
  input  logic                               REF_ACK,
  output logic                               NOP,
  output logic                               READA,
  output logic                               WRITEA,
  output logic [ASIZE-1:0]                   SADDR,
  output logic                               CMD_ACK,
  output logic                               PRECHARGE,
  output logic                               REFRESH,
  output logic                               LOAD_MODE,
  output logic                               INIT_REQ,
  output logic                               INIT_DONE,
  output logic                               REF_REQ,
  output logic [$clog2(MAX_PENDING+1)-1:0]   REF_PENDING,
  output logic                               REF_URGENT,
  output logic                               REF_OVERRUN
);

  localparam int CNT_MAX = (INIT_CYCLES + 1 > REF_GAP) ? INIT_CYCLES + 1 : REF_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int RC_W    = (INIT_REFRESH > 1) ? $clog2(INIT_REFRESH) : 1;
  localparam int TMR_W   = $clog2(REF_PER);
  localparam int PEND_W  = $clog2(MAX_PENDING + 1);

  typedef enum logic [1:0] {S_WAIT, S_REF, S_LMR, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic [ASIZE-1:0]   saddr_q, saddr_d;
  logic nop_q, nop_d, reada_q, reada_d, writea_q, writea_d;
  logic cm_ack_dly_q, cmd_ack_q, cmd_ack_d;
  logic precharge_q, precharge_d, refresh_q, refresh_d, load_mode_q, load_mode_d;
  logic init_req_q, init_req_d, init_done_q, init_done_d;
  logic ref_req_q, ref_req_d, urgent_q, urgent_d, overrun_q, overrun_d;
  logic tick;

  // Next-state logic: decode, init sequencing, refresh timer and queue.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rc_d        = rc_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    overrun_d   = overrun_q;
    init_done_d = init_done_q;
    init_req_d  = 1'b0;
    precharge_d = 1'b0;
    refresh_d   = 1'b0;
    load_mode_d = 1'b0;
    tick        = 1'b0;

    saddr_d   = ADDR;
    nop_d     = (CMD == 3'b000);
    reada_d   = (CMD == 3'b001) && init_done_q;
    writea_d  = (CMD == 3'b010) && init_done_q;
    cmd_ack_d = CM_ACK & ~cm_ack_dly_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES)) begin
          precharge_d = 1'b1;
          cnt_d       = CNT_W'(0);
          state_d     = S_REF;
        end else begin
          init_req_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end
      S_REF: begin
        if (cnt_q == CNT_W'(REF_GAP - 1)) begin
          refresh_d = 1'b1;
          cnt_d     = CNT_W'(0);
          if (rc_q == RC_W'(INIT_REFRESH - 1)) begin
            rc_d    = RC_W'(0);
            state_d = S_LMR;
          end else begin
            rc_d = rc_q + RC_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LMR: begin
        if (cnt_q == CNT_W'(REF_GAP - 1)) begin
          load_mode_d = 1'b1;
          cnt_d       = CNT_W'(0);
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        init_done_d = 1'b1;
        // Timer is first loaded on the cycle INIT_DONE goes high.
        if (!init_done_q) begin
          timer_d = TMR_W'(REF_PER - 1);
        end else if (timer_q == TMR_W'(0)) begin
          timer_d = TMR_W'(REF_PER - 1);
          tick    = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase

    if (tick && !REF_ACK) begin
      if (pend_q == PEND_W'(MAX_PENDING)) begin
        overrun_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (REF_ACK && !tick && init_done_q && (pend_q != PEND_W'(0))) begin
      pend_d = pend_q - PEND_W'(1);
    end else begin
      pend_d = pend_q;
    end

    ref_req_d = (pend_d != PEND_W'(0));
    urgent_d  = (pend_d == PEND_W'(MAX_PENDING));
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      rc_q         <= '0;
      timer_q      <= '0;
      pend_q       <= '0;
      saddr_q      <= '0;
      nop_q        <= 1'b0;
      reada_q      <= 1'b0;
      writea_q     <= 1'b0;
      cm_ack_dly_q <= 1'b0;
      cmd_ack_q    <= 1'b0;
      precharge_q  <= 1'b0;
      refresh_q    <= 1'b0;
      load_mode_q  <= 1'b0;
      init_req_q   <= 1'b0;
      init_done_q  <= 1'b0;
      ref_req_q    <= 1'b0;
      urgent_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rc_q         <= rc_d;
      timer_q      <= timer_d;
      pend_q       <= pend_d;
      saddr_q      <= saddr_d;
      nop_q        <= nop_d;
      reada_q      <= reada_d;
      writea_q     <= writea_d;
      cm_ack_dly_q <= CM_ACK;
      cmd_ack_q    <= cmd_ack_d;
      precharge_q  <= precharge_d;
      refresh_q    <= refresh_d;
      load_mode_q  <= load_mode_d;
      init_req_q   <= init_req_d;
      init_done_q  <= init_done_d;
      ref_req_q    <= ref_req_d;
      urgent_q     <= urgent_d;
      overrun_q    <= overrun_d;
    end
  end

  assign NOP         = nop_q;
  assign READA       = reada_q;
  assign WRITEA      = writea_q;
  assign SADDR       = saddr_q;
  assign CMD_ACK     = cmd_ack_q;
  assign PRECHARGE   = precharge_q;
  assign REFRESH     = refresh_q;
  assign LOAD_MODE   = load_mode_q;
  assign INIT_REQ    = init_req_q;
  assign INIT_DONE   = init_done_q;
  assign REF_REQ     = ref_req_q;
  assign REF_PENDING = pend_q;
  assign REF_URGENT  = urgent_q;
  assign REF_OVERRUN = overrun_q;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Scoreboard bench: a timeline model predicts every output each cycle,
// a negedge monitor pops the prediction and compares it with the DUT.
module tb_sdram_init_refresh_ctrl;

  localparam int ASIZE = 23;
  localparam int IC    = 10;
  localparam int NR    = 2;
  localparam int GAP   = 4;
  localparam int PER   = 20;
  localparam int MAXP  = 3;
  localparam int LMR_T = IC + (NR + 1) * GAP;
  localparam int D     = LMR_T + 1;

  logic             clk, rst, cm_ack, ref_ack;
  logic [2:0]       cmd;
  logic [ASIZE-1:0] addr;
  logic             nop_o, reada_o, writea_o, cmd_ack_o;
  logic [ASIZE-1:0] saddr_o;
  logic             pre_o, ref_o, lmr_o, init_req_o, init_done_o;
  logic             ref_req_o, urgent_o, overrun_o;
  logic [1:0]       pend_o;

  sdram_init_refresh_ctrl #(
    .ASIZE(ASIZE), .INIT_CYCLES(IC), .INIT_REFRESH(NR),
    .REF_GAP(GAP), .REF_PER(PER), .MAX_PENDING(MAXP)
  ) dut (
    .CLK(clk), .RESET(rst), .CMD(cmd), .ADDR(addr), .CM_ACK(cm_ack), .REF_ACK(ref_ack),
    .NOP(nop_o), .READA(reada_o), .WRITEA(writea_o), .SADDR(saddr_o), .CMD_ACK(cmd_ack_o),
    .PRECHARGE(pre_o), .REFRESH(ref_o), .LOAD_MODE(lmr_o), .INIT_REQ(init_req_o),
    .INIT_DONE(init_done_o), .REF_REQ(ref_req_o), .REF_PENDING(pend_o),
    .REF_URGENT(urgent_o), .REF_OVERRUN(overrun_o)
  );

  typedef struct packed {
    logic             nop, reada, writea;
    logic [ASIZE-1:0] saddr;
    logic             cmd_ack, pre, refr, lmr, init_req, init_done, ref_req;
    logic [1:0]       pend;
    logic             urgent, overrun;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   t_next = 0;
  int   cur_t  = -1;
  int   m_pend = 0;
  bit   m_ovr  = 1'b0;
  bit   m_prev_cm = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, cur_t, $time);
    end
  endtask

  // Prediction for the cycle that follows this edge, from the cycle index since reset release.
  task automatic model_step();
    exp_t e;
    int   tt;
    bit   done_prev, tick;
    e = '0;
    if (rst) begin
      t_next = 0; cur_t = -1; m_pend = 0; m_ovr = 1'b0; m_prev_cm = 1'b0;
    end else begin
      tt = t_next;
      cur_t = tt;
      t_next++;
      done_prev   = (tt >= D + 1);
      e.saddr     = addr;
      e.nop       = (cmd == 3'd0);
      e.reada     = (cmd == 3'd1) && done_prev;
      e.writea    = (cmd == 3'd2) && done_prev;
      e.cmd_ack   = cm_ack && !m_prev_cm;
      m_prev_cm   = cm_ack;
      e.init_req  = (tt < IC);
      e.pre       = (tt == IC);
      e.refr      = (tt > IC) && ((tt - IC) % GAP == 0) && ((tt - IC) / GAP <= NR);
      e.lmr       = (tt == LMR_T);
      e.init_done = (tt >= D);
      tick = (tt > D) && ((tt - D) % PER == 0);
      if (tick && !ref_ack) begin
        if (m_pend == MAXP) m_ovr = 1'b1;
        else m_pend++;
      end else if (ref_ack && !tick && m_pend > 0) begin
        m_pend--;
      end
      e.pend    = 2'(m_pend);
      e.ref_req = (m_pend != 0);
      e.urgent  = (m_pend == MAXP);
      e.overrun = m_ovr;
    end
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Monitor: compare every registered output against the queued prediction.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("NOP",         32'(nop_o),       32'(e.nop));
      chk("READA",       32'(reada_o),     32'(e.reada));
      chk("WRITEA",      32'(writea_o),    32'(e.writea));
      chk("SADDR",       32'(saddr_o),     32'(e.saddr));
      chk("CMD_ACK",     32'(cmd_ack_o),   32'(e.cmd_ack));
      chk("PRECHARGE",   32'(pre_o),       32'(e.pre));
      chk("REFRESH",     32'(ref_o),       32'(e.refr));
      chk("LOAD_MODE",   32'(lmr_o),       32'(e.lmr));
      chk("INIT_REQ",    32'(init_req_o),  32'(e.init_req));
      chk("INIT_DONE",   32'(init_done_o), 32'(e.init_done));
      chk("REF_REQ",     32'(ref_req_o),   32'(e.ref_req));
      chk("REF_PENDING", 32'(pend_o),      32'(e.pend));
      chk("REF_URGENT",  32'(urgent_o),    32'(e.urgent));
      chk("REF_OVERRUN", 32'(overrun_o),   32'(e.overrun));
    end
  end

  task automatic drive_random(input int ack_div);
    cmd     = 3'($urandom_range(0, 7));
    addr    = ASIZE'($urandom);
    cm_ack  = ($urandom_range(0, 3) == 0);
    ref_ack = ($urandom_range(0, ack_div - 1) == 0);
  endtask

  initial begin
    int guard;
    bit reached;
    rst = 1'b1; cmd = 3'd0; addr = '0; cm_ack = 1'b0; ref_ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Directed run: init timing, decode gating, CMD_ACK edges, queue fill/overrun/drain.
    guard = 0;
    while (cur_t < 130 && guard < 400) begin
      cmd     = 3'($urandom_range(0, 7));
      addr    = ASIZE'($urandom);
      cm_ack  = (cur_t >= 40 && cur_t <= 44) || (cur_t >= 47 && cur_t <= 49);
      ref_ack = (cur_t == 15) || (cur_t == 110) || (cur_t == 112) || (cur_t == 122);
      if (cur_t == 5)  cmd = 3'b001;
      if (cur_t == 30) begin cmd = 3'b010; addr = ASIZE'(32'h1234); end
      if (cur_t == 31) cmd = 3'b111;
      step();
      guard++;
    end

    rst = 1'b1; step(); rst = 1'b0;

    // Reset in the middle of the init refresh phase.
    guard = 0;
    while (cur_t != 16 && guard < 100) begin
      drive_random(1000000); ref_ack = 1'b0; step(); guard++;
    end
    rst = 1'b1; step(); rst = 1'b0;

    // Run until two refreshes are queued, then reset.
    guard = 0; reached = 1'b0;
    while (!reached && guard < 200) begin
      drive_random(1000000); ref_ack = 1'b0; step(); guard++;
      reached = (m_pend == 2);
    end
    chk("pend2_reached", 32'(reached), 32'd1);
    repeat (3) begin drive_random(1000000); ref_ack = 1'b0; step(); end
    rst = 1'b1; step(); rst = 1'b0;

    // Random traffic across init and refresh operation.
    repeat (700) begin drive_random(25); step(); end
    cmd = 3'd0; cm_ack = 1'b0; ref_ack = 1'b0;
    repeat (2) step();
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
